// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch access controller for the IF stage.
// Scratch-pad (SPM) hits are answered combinationally in the same cycle;
// every other address runs a request/grant/ready bus transaction with
// flush draining and an access timeout.
module if_fetch_ctrl #(
    parameter logic [2:0] SPM_IDX = 3'h1,
    parameter int         TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] insn,
    output logic        busy,
    output logic        fetch_err,
    output logic [29:0] spm_addr,
    output logic        spm_as,
    input  logic [31:0] spm_rd_data,
    output logic        bus_req,
    input  logic        bus_grnt,
    output logic [29:0] bus_addr,
    output logic        bus_as,
    input  logic [31:0] bus_rd_data,
    input  logic        bus_rdy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q,    state_d;
    logic        bus_req_q,  bus_req_d;
    logic        bus_as_q,   bus_as_d;
    logic [29:0] bus_addr_q, bus_addr_d;
    logic [31:0] rd_buf_q,   rd_buf_d;
    logic        drop_q,     drop_d;
    logic [7:0]  tcnt_q,     tcnt_d;

    logic [31:0] insn_s;
    logic        busy_s;
    logic        fetch_err_s;
    logic        spm_as_s;
    logic        spm_hit_s;

    assign spm_hit_s = (addr[29:27] == SPM_IDX);

    // Next-state and per-state output decode for the fetch FSM.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_as_d    = 1'b0;
        bus_addr_d  = bus_addr_q;
        rd_buf_d    = rd_buf_q;
        drop_d      = drop_q;
        tcnt_d      = tcnt_q;
        insn_s      = NOP;
        busy_s      = 1'b0;
        fetch_err_s = 1'b0;
        spm_as_s    = 1'b0;

        case (state_q)
            IDLE: begin
                if (spm_hit_s) begin
                    spm_as_s = 1'b1;
                    insn_s   = spm_rd_data;
                end else if (!flush) begin
                    busy_s     = 1'b1;
                    bus_req_d  = 1'b1;
                    bus_addr_d = addr;
                    state_d    = REQ;
                end else begin
                    // Flushed miss: hand a NOP down and make no request.
                    insn_s = NOP;
                end
            end

            REQ: begin
                busy_s = 1'b1;
                if (flush) begin
                    // Flush beats a simultaneous grant: no strobe is issued.
                    bus_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (bus_grnt) begin
                    bus_as_d = 1'b1;
                    tcnt_d   = 8'd0;
                    state_d  = ACCESS;
                end else begin
                    state_d = REQ;
                end
            end

            ACCESS: begin
                tcnt_d = tcnt_q + 8'd1;
                if (bus_rdy) begin
                    // Ready wins over a timeout in the same cycle.
                    bus_req_d = 1'b0;
                    drop_d    = 1'b0;
                    if (drop_q || flush) begin
                        insn_s  = NOP;
                        state_d = IDLE;
                    end else if (stall) begin
                        insn_s   = bus_rd_data;
                        rd_buf_d = bus_rd_data;
                        state_d  = WAIT;
                    end else begin
                        insn_s  = bus_rd_data;
                        state_d = IDLE;
                    end
                end else if (tcnt_q == TMO_LAST) begin
                    fetch_err_s = 1'b1;
                    bus_req_d   = 1'b0;
                    drop_d      = 1'b0;
                    state_d     = IDLE;
                end else if (flush) begin
                    // Transaction cannot be aborted: remember to discard it,
                    // and release the pipeline for the flush cycle itself.
                    drop_d = 1'b1;
                end else begin
                    busy_s = 1'b1;
                end
            end

            WAIT: begin
                insn_s = rd_buf_q;
                if (!stall || flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end

            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and bus-side registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bus_req_q  <= 1'b0;
            bus_as_q   <= 1'b0;
            bus_addr_q <= 30'h0;
            rd_buf_q   <= 32'h0;
            drop_q     <= 1'b0;
            tcnt_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            bus_req_q  <= bus_req_d;
            bus_as_q   <= bus_as_d;
            bus_addr_q <= bus_addr_d;
            rd_buf_q   <= rd_buf_d;
            drop_q     <= drop_d;
            tcnt_q     <= tcnt_d;
        end
    end

    // Pipeline-facing outputs are held quiet while reset is asserted.
    assign insn      = reset ? insn_s      : 32'h0;
    assign busy      = reset ? busy_s      : 1'b0;
    assign fetch_err = reset ? fetch_err_s : 1'b0;
    assign spm_as    = reset ? spm_as_s    : 1'b0;

    assign spm_addr = addr;
    assign bus_req  = bus_req_q;
    assign bus_as   = bus_as_q;
    assign bus_addr = bus_addr_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with an expected-instruction scoreboard.
module tb_if_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [29:0] addr;
    logic        stall;
    logic        flush;
    logic [31:0] insn;
    logic        busy;
    logic        fetch_err;
    logic [29:0] spm_addr;
    logic        spm_as;
    logic [31:0] spm_rd_data;
    logic        bus_req;
    logic        bus_grnt;
    logic [29:0] bus_addr;
    logic        bus_as;
    logic [31:0] bus_rd_data;
    logic        bus_rdy;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] exp_q[$];

    localparam logic [29:0] A_SPM = 30'h0800_0010;
    localparam logic [29:0] A_BUS = 30'h1000_0004;

    if_fetch_ctrl #(.SPM_IDX(3'h1), .TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .stall       (stall),
        .flush       (flush),
        .insn        (insn),
        .busy        (busy),
        .fetch_err   (fetch_err),
        .spm_addr    (spm_addr),
        .spm_as      (spm_as),
        .spm_rd_data (spm_rd_data),
        .bus_req     (bus_req),
        .bus_grnt    (bus_grnt),
        .bus_addr    (bus_addr),
        .bus_as      (bus_as),
        .bus_rd_data (bus_rd_data),
        .bus_rdy     (bus_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_insn(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk_insn(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            total_cnt = total_cnt + 1;
            fail_cnt  = fail_cnt + 1;
            $error("FAIL %s: observed %h expected <empty scoreboard>", tag, insn);
        end else begin
            e = exp_q.pop_front();
            chk(tag, insn, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; addr = A_BUS; stall = 1'b0; flush = 1'b0;
        spm_rd_data = 32'hDEAD_BEEF; bus_grnt = 1'b0;
        bus_rd_data = 32'h0; bus_rdy = 1'b0;

        // Reset state: outputs forced low even with a miss address.
        smp();
        push_insn(32'h0); chk_insn("rst_insn");
        chk("rst_busy", busy, 32'd0);
        chk("rst_req", bus_req, 32'd0);
        chk("rst_as", bus_as, 32'd0);
        chk("rst_spm_as", spm_as, 32'd0);
        chk("rst_err", fetch_err, 32'd0);
        chk("rst_baddr", bus_addr, 32'd0);

        // SPM fetch, same cycle.
        cyc(); reset = 1'b1; addr = A_SPM;
        smp();
        push_insn(32'hDEAD_BEEF); chk_insn("spm_insn");
        chk("spm_busy", busy, 32'd0);
        chk("spm_as", spm_as, 32'd1);
        chk("spm_addr", spm_addr, 32'(A_SPM));
        chk("spm_req0", bus_req, 32'd0);
        cyc(); smp();
        chk("spm_req1", bus_req, 32'd0);

        // Bus fetch: grant after 2 REQ cycles, ready 3 cycles after bus_as.
        cyc(); addr = A_BUS;
        smp();
        chk("bf_idle_busy", busy, 32'd1);
        chk("bf_idle_spm", spm_as, 32'd0);
        push_insn(32'h0); chk_insn("bf_idle_insn");
        cyc(); smp();
        chk("bf_req_busy", busy, 32'd1);
        chk("bf_req", bus_req, 32'd1);
        chk("bf_baddr", bus_addr, 32'(A_BUS));
        cyc(); bus_grnt = 1'b1;
        smp();
        chk("bf_req2_as", bus_as, 32'd0);
        cyc(); bus_grnt = 1'b0;
        smp();
        chk("bf_a1_as", bus_as, 32'd1);
        chk("bf_a1_busy", busy, 32'd1);
        cyc(); smp();
        chk("bf_a2_as", bus_as, 32'd0);
        chk("bf_a2_req", bus_req, 32'd1);
        cyc(); smp();
        chk("bf_a3_busy", busy, 32'd1);
        chk("bf_a3_baddr", bus_addr, 32'(A_BUS));
        cyc(); bus_rdy = 1'b1; bus_rd_data = 32'h1234_5678;
        push_insn(32'h1234_5678);
        smp();
        chk_insn("bf_rdy_insn");
        chk("bf_rdy_busy", busy, 32'd0);
        cyc(); bus_rdy = 1'b0; bus_rd_data = 32'h0; addr = A_SPM;
        smp();
        chk("bf_done_req", bus_req, 32'd0);
        chk("bf_done_as", bus_as, 32'd0);

        // Stall hold through WAIT.
        cyc(); addr = A_BUS;
        cyc(); bus_grnt = 1'b1;
        cyc(); bus_grnt = 1'b0;
        cyc();
        cyc();
        cyc(); bus_rdy = 1'b1; stall = 1'b1; bus_rd_data = 32'h1234_5678;
        push_insn(32'h1234_5678);
        smp();
        chk_insn("st_rdy_insn");
        chk("st_rdy_busy", busy, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(); bus_rdy = 1'b0; bus_rd_data = 32'hFFFF_0000;
            push_insn(32'h1234_5678);
            smp();
            chk_insn("st_wait_insn");
            chk("st_wait_busy", busy, 32'd0);
            chk("st_wait_req", bus_req, 32'd0);
        end
        cyc(); stall = 1'b0; addr = A_SPM;
        push_insn(32'h1234_5678);
        smp();
        chk_insn("st_last_insn");
        chk("st_last_spm", spm_as, 32'd0);
        cyc();
        push_insn(32'hDEAD_BEEF);
        smp();
        chk("st_idle_spm", spm_as, 32'd1);
        chk_insn("st_idle_insn");

        // Flush during ACCESS: data is drained and dropped.
        cyc(); addr = A_BUS;
        cyc(); bus_grnt = 1'b1;
        cyc(); bus_grnt = 1'b0;
        smp();
        chk("fl_a1_as", bus_as, 32'd1);
        cyc(); flush = 1'b1;
        push_insn(32'h0);
        smp();
        chk("fl_flush_busy", busy, 32'd0);
        chk_insn("fl_flush_insn");
        cyc(); flush = 1'b0; addr = A_SPM;
        smp();
        chk("fl_drain_busy", busy, 32'd1);
        cyc(); bus_rdy = 1'b1; bus_rd_data = 32'hAAAA_AAAA;
        push_insn(32'h0);
        smp();
        chk_insn("fl_rdy_insn");
        chk("fl_rdy_busy", busy, 32'd0);
        cyc(); bus_rdy = 1'b0;
        push_insn(32'hDEAD_BEEF);
        smp();
        chk("fl_done_req", bus_req, 32'd0);
        chk_insn("fl_done_insn");

        // Grant and flush together in REQ: flush wins.
        cyc(); addr = A_BUS;
        cyc(); bus_grnt = 1'b1; flush = 1'b1; addr = A_SPM;
        smp();
        chk("gf_req_busy", busy, 32'd1);
        cyc(); bus_grnt = 1'b0; flush = 1'b0;
        smp();
        chk("gf_as", bus_as, 32'd0);
        chk("gf_req", bus_req, 32'd0);
        chk("gf_spm", spm_as, 32'd1);

        // Timeout after 8 ACCESS cycles, stray ready afterwards.
        cyc(); addr = A_BUS;
        cyc(); bus_grnt = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(); bus_grnt = 1'b0;
            smp();
            chk("to_wait_err", fetch_err, 32'd0);
            chk("to_wait_busy", busy, 32'd1);
        end
        cyc();
        push_insn(32'h0);
        smp();
        chk("to_err", fetch_err, 32'd1);
        chk("to_busy", busy, 32'd0);
        chk_insn("to_insn");
        cyc(); addr = A_SPM;
        smp();
        chk("to_next_req", bus_req, 32'd0);
        chk("to_next_err", fetch_err, 32'd0);
        cyc(); bus_rdy = 1'b1; bus_rd_data = 32'h5555_5555;
        push_insn(32'hDEAD_BEEF);
        smp();
        chk_insn("to_stray_insn");
        chk("to_stray_req", bus_req, 32'd0);
        chk("to_stray_err", fetch_err, 32'd0);
        chk("to_stray_busy", busy, 32'd0);

        // Ready in the timeout cycle: ready wins, no error.
        cyc(); bus_rdy = 1'b0; addr = A_BUS;
        cyc(); bus_grnt = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(); bus_grnt = 1'b0;
        end
        cyc(); bus_rdy = 1'b1; bus_rd_data = 32'h0BAD_F00D;
        push_insn(32'h0BAD_F00D);
        smp();
        chk("rt_err", fetch_err, 32'd0);
        chk_insn("rt_insn");
        chk("rt_busy", busy, 32'd0);
        cyc(); bus_rdy = 1'b0; addr = A_SPM;
        smp();
        chk("rt_done_req", bus_req, 32'd0);

        // Asynchronous reset in the middle of REQ.
        cyc(); addr = A_BUS;
        cyc();
        smp();
        chk("ar_pre_req", bus_req, 32'd1);
        chk("ar_pre_busy", busy, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("ar_req", bus_req, 32'd0);
        chk("ar_as", bus_as, 32'd0);
        chk("ar_busy", busy, 32'd0);
        cyc(); reset = 1'b1; addr = A_SPM;
        push_insn(32'hDEAD_BEEF);
        smp();
        chk_insn("ar_after_insn");
        chk("ar_after_req", bus_req, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
